// File: rtl/point_sequencer.sv
// Walks a completed point frame by buffer index and drives the X/Y DACs,
// holding each point for a dwell that grows with beam travel before moving on.
module point_sequencer #(
    parameter int unsigned BASE_DWELL  = 4,
    parameter int unsigned BLANK_DWELL = 8,
    parameter int unsigned SLEW_SHIFT  = 6,
    parameter int unsigned CENTER      = 2048
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        drawing,
    input  logic [10:0] num_pts,
    input  logic [24:0] point,
    output logic [10:0] index,
    output logic        done_drawing,
    output logic [11:0] x_out,
    output logic [11:0] y_out,
    output logic        blank,
    output logic        dac_load
);

    typedef enum logic [2:0] {IDLE, FETCH, LATCH, DWELL, DONE} state_t;

    function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
        logic signed [12:0] d;
        logic signed [12:0] nd;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        nd = -d;
        return d[12] ? nd[11:0] : d[11:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    state_t      state_q, state_d;
    logic [10:0] index_q, index_d;
    logic [10:0] n_lat_q, n_lat_d;
    logic [15:0] cnt_q, cnt_d;
    // The DAC output registers double as the previous beam position.
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        blank_q, blank_d;
    logic        load_q, load_d;
    logic        done_q, done_d;

    logic [11:0] dx, dy, dmax, slew;
    logic [15:0] base, dwell;

    always_comb begin
        dx    = abs_diff(point[11:0], x_q);
        dy    = abs_diff(point[23:12], y_q);
        dmax  = (dx > dy) ? dx : dy;
        slew  = dmax >> SLEW_SHIFT;
        base  = point[24] ? 16'(BASE_DWELL) : 16'(BLANK_DWELL);
        dwell = sat_add16(base, {4'b0, slew});
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        n_lat_d = n_lat_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        blank_d = blank_q;
        load_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                blank_d = 1'b1;
                if (drawing) begin
                    n_lat_d = num_pts;
                    index_d = '0;
                    if (num_pts == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                x_d     = point[11:0];
                y_d     = point[23:12];
                blank_d = ~point[24];
                load_d  = 1'b1;
                cnt_d   = dwell;
                state_d = DWELL;
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    if (index_q == n_lat_q - 11'd1) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        blank_d = 1'b1;
                    end else begin
                        index_d = index_q + 11'd1;
                        state_d = FETCH;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            DONE: begin
                blank_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            index_q <= '0;
            n_lat_q <= '0;
            cnt_q   <= '0;
            x_q     <= 12'(CENTER);
            y_q     <= 12'(CENTER);
            blank_q <= 1'b1;
            load_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            n_lat_q <= n_lat_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blank_q <= blank_d;
            load_q  <= load_d;
            done_q  <= done_d;
        end
    end

    assign index        = index_q;
    assign done_drawing = done_q;
    assign x_out        = x_q;
    assign y_out        = y_q;
    assign blank        = blank_q;
    assign dac_load     = load_q;

endmodule

// File: tb/tb_point_sequencer.sv
// Directed bench for point_sequencer: frame timing, dwell, index walk and reset.
module tb_point_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        drawing = 1'b0;
    logic [10:0] num_pts = '0;
    logic [24:0] point;
    logic [10:0] index;
    logic        done_drawing;
    logic [11:0] x_out, y_out;
    logic        blank, dac_load;

    logic [24:0] mem [0:2047];

    int npass = 0;
    int nchk  = 0;
    int nload, done_cyc;
    int          ld_cyc [8];
    logic [11:0] ld_x   [8];
    logic        ld_blk [8];
    logic [10:0] ld_idx [8];

    point_sequencer dut (
        .clk(clk), .reset_n(reset_n), .drawing(drawing), .num_pts(num_pts),
        .point(point), .index(index), .done_drawing(done_drawing),
        .x_out(x_out), .y_out(y_out), .blank(blank), .dac_load(dac_load)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous read buffer
    always @(posedge clk) point <= mem[index];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [10:0] n);
        drawing = 1'b1;
        num_pts = n;
        step();
    endtask

    task automatic run_frame(input int maxc, input bit mid);
        int cyc;
        nload    = 0;
        done_cyc = 0;
        cyc      = 1;
        while (cyc <= maxc) begin
            if (dac_load) begin
                if (nload < 8) begin
                    ld_cyc[nload] = cyc;
                    ld_x[nload]   = x_out;
                    ld_blk[nload] = blank;
                    ld_idx[nload] = index;
                end
                nload++;
            end
            if (done_drawing) begin
                done_cyc = cyc;
                break;
            end
            if (mid && cyc == 10) begin
                drawing = 1'b0;
                num_pts = 11'd7;
            end
            step();
            cyc++;
        end
    endtask

    initial begin
        int c;
        repeat (3) step();
        chk("rst_x", 32'(x_out), 2048);
        chk("rst_y", 32'(y_out), 2048);
        chk("rst_blank", 32'(blank), 1);
        chk("rst_index", 32'(index), 0);
        chk("rst_done", 32'(done_drawing), 0);
        chk("rst_load", 32'(dac_load), 0);
        reset_n = 1'b1;
        c = 0;
        repeat (20) begin
            step();
            if (dac_load || done_drawing) c++;
        end
        chk("idle_quiet", 32'(c), 0);

        // Single lit point from center: dx=640 -> dwell 14
        mem[0] = {1'b1, 12'd2048, 12'd2688};
        start_frame(11'd1);
        drawing = 1'b0;
        run_frame(100, 1'b0);
        chk("p1_done_cyc", 32'(done_cyc), 18);
        chk("p1_loads", 32'(nload), 1);
        chk("p1_load_cyc", 32'(ld_cyc[0]), 3);
        chk("p1_x", 32'(ld_x[0]), 2688);
        chk("p1_blank", 32'(ld_blk[0]), 0);
        chk("p1_done_blank", 32'(blank), 1);
        chk("p1_done_hold_x", 32'(x_out), 2688);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        // Blanked point (dwell 38) then lit point (dwell 5)
        mem[0] = {1'b0, 12'd100, 12'd100};
        mem[1] = {1'b1, 12'd100, 12'd164};
        start_frame(11'd2);
        drawing = 1'b0;
        run_frame(200, 1'b0);
        chk("p2_done_cyc", 32'(done_cyc), 50);
        chk("p2_loads", 32'(nload), 2);
        chk("p2_idx0", 32'(ld_idx[0]), 0);
        chk("p2_idx1", 32'(ld_idx[1]), 1);
        chk("p2_load_cyc1", 32'(ld_cyc[1]), 44);
        chk("p2_blank0", 32'(ld_blk[0]), 1);
        chk("p2_blank1", 32'(ld_blk[1]), 0);
        chk("p2_x1", 32'(ld_x[1]), 164);
        step();
        step();

        // Empty frame
        drawing = 1'b1;
        num_pts = 11'd0;
        chk("e_done_before", 32'(done_drawing), 0);
        step();
        chk("e_done", 32'(done_drawing), 1);
        chk("e_x_hold", 32'(x_out), 164);
        chk("e_no_load", 32'(dac_load), 0);
        drawing = 1'b0;
        step();
        chk("e_done_pulse", 32'(done_drawing), 0);
        step();

        // drawing dropped and num_pts changed during point 1
        mem[0] = {1'b1, 12'd100, 12'd164};
        mem[1] = {1'b1, 12'd100, 12'd228};
        mem[2] = {1'b0, 12'd100, 12'd228};
        start_frame(11'd3);
        run_frame(200, 1'b1);
        chk("m_done_cyc", 32'(done_cyc), 27);
        chk("m_loads", 32'(nload), 3);
        chk("m_idx2", 32'(ld_idx[2]), 2);
        chk("m_load_cyc2", 32'(ld_cyc[2]), 18);
        chk("m_blank2", 32'(ld_blk[2]), 1);
        chk("m_index_end", 32'(index), 2);
        c = 0;
        repeat (30) begin
            step();
            if (dac_load || done_drawing) c++;
        end
        chk("m_after_quiet", 32'(c), 0);

        // Reset during DWELL of point 1
        mem[0] = {1'b1, 12'd100, 12'd228};
        mem[1] = {1'b1, 12'd100, 12'd1000};
        start_frame(11'd2);
        drawing = 1'b0;
        repeat (11) step();
        chk("r_pre_x", 32'(x_out), 1000);
        chk("r_pre_index", 32'(index), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_x", 32'(x_out), 2048);
        chk("r_y", 32'(y_out), 2048);
        chk("r_blank", 32'(blank), 1);
        chk("r_index", 32'(index), 0);
        c = 0;
        repeat (3) begin
            step();
            if (done_drawing || dac_load) c++;
        end
        chk("r_no_done", 32'(c), 0);
        reset_n = 1'b1;
        step();
        mem[0] = {1'b1, 12'd2048, 12'd2112};
        start_frame(11'd1);
        drawing = 1'b0;
        run_frame(100, 1'b0);
        chk("r2_done_cyc", 32'(done_cyc), 9);
        chk("r2_loads", 32'(nload), 1);
        chk("r2_x", 32'(ld_x[0]), 2112);
        chk("r2_idx", 32'(ld_idx[0]), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
